// File: rtl/flush_ctrl.sv
// Misprediction flush generator at EX: raises a registered flush, issues one
// valid/ready redirect with the corrected PC, and counts mispredictions.
module flush_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic             stall,
  output logic             flush_signal,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             busy,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned FC_W = 4;
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [FC_W-1:0]   fcnt, fcnt_nxt;
  logic              done, done_nxt;
  logic              flush_nxt;
  logic              rv_nxt;
  logic [XLEN-1:0]   pc_nxt;
  logic [CNT_W-1:0]  mcnt_nxt;

  logic              resolved;
  logic              taken;
  logic              tgt_mismatch;
  logic              mispredict;
  logic [XLEN-1:0]   corr_pc;
  logic              hs;

  // Outcome resolution against the fetch-time prediction
  always_comb begin
    resolved     = ex_valid & ~stall;
    taken        = ex_is_jump | ex_taken;
    tgt_mismatch = (ex_target != ex_pred_target);
    mispredict   = resolved &
                   ((ex_is_jump & (~ex_pred_taken | tgt_mismatch)) |
                    (ex_is_branch & (ex_taken != ex_pred_taken)) |
                    (ex_is_branch & ex_taken & ex_pred_taken & tgt_mismatch));
    corr_pc      = taken ? ex_target : (ex_pc + XLEN'(4));
    hs           = redirect_valid & redirect_ready;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    done_nxt  = done;
    rv_nxt    = redirect_valid & ~hs;
    pc_nxt    = redirect_pc;
    mcnt_nxt  = mispredict_cnt;
    case (state)
      IDLE: begin
        if (mispredict) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FC_LOAD;
          done_nxt  = 1'b0;
          rv_nxt    = 1'b1;
          pc_nxt    = corr_pc;
          if (mispredict_cnt != CNT_MAX) begin
            mcnt_nxt = mispredict_cnt + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        done_nxt = done | hs;
        // A stalled cycle does not count toward the minimum flush length
        if (!stall) begin
          fcnt_nxt = fcnt - FC_W'(1);
          if (fcnt == FC_W'(1)) begin
            state_nxt = (done | hs) ? IDLE : HOLD;
          end
        end
      end
      HOLD: begin
        done_nxt = done | hs;
        if (hs) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    flush_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      fcnt           <= '0;
      done           <= 1'b0;
      flush_signal   <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
    end else begin
      state          <= state_nxt;
      fcnt           <= fcnt_nxt;
      done           <= done_nxt;
      flush_signal   <= flush_nxt;
      busy           <= flush_nxt;
      redirect_valid <= rv_nxt;
      redirect_pc    <= pc_nxt;
      mispredict_cnt <= mcnt_nxt;
    end
  end

endmodule

// File: tb/tb_flush_ctrl.sv
// Directed bench for flush_ctrl: a cycle-level reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_flush_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        stall;
  logic        redirect_ready;

  logic        flush_signal, redirect_valid, busy;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_cnt;

  logic        s_flush, s_rv, s_busy;
  logic [31:0] s_pc;
  logic [1:0]  s_cnt;

  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int flush_cycles = 0;

  flush_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_target(ex_pred_target),
    .stall(stall),
    .flush_signal(flush_signal), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .busy(busy), .mispredict_cnt(mispredict_cnt)
  );

  flush_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_target(ex_pred_target),
    .stall(stall),
    .flush_signal(s_flush), .redirect_valid(s_rv),
    .redirect_pc(s_pc), .redirect_ready(redirect_ready),
    .busy(s_busy), .mispredict_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: remaining unstalled flush cycles plus an outstanding redirect
  bit          m_active, m_pend, m_mp;
  int          m_rem;
  logic [31:0] m_pc;
  int          m_cnt, m_sat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_pend = 0; m_rem = 0; m_pc = '0; m_cnt = 0; m_sat = 0;
    end else begin
      m_mp = ex_valid && !stall &&
             ((ex_is_jump && (!ex_pred_taken || ex_target != ex_pred_target)) ||
              (ex_is_branch && (ex_taken != ex_pred_taken)) ||
              (ex_is_branch && ex_taken && ex_pred_taken && ex_target != ex_pred_target));
      if (m_active) begin
        if (m_pend && redirect_ready) m_pend = 0;
        if (!stall && m_rem > 0) m_rem--;
        if (m_rem == 0 && !m_pend) m_active = 0;
      end else if (m_mp) begin
        m_active = 1;
        m_pend   = 1;
        m_rem    = 2;
        m_pc     = (ex_is_jump || ex_taken) ? ex_target : ex_pc + 32'd4;
        if (m_cnt < 65535) m_cnt++;
        if (m_sat < 3) m_sat++;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && redirect_valid && redirect_ready) hs_cnt++;
  end

  always @(negedge clk) begin
    if (flush_signal) flush_cycles++;
    check("flush", 64'(flush_signal), 64'(m_active));
    check("busy", 64'(busy), 64'(m_active));
    check("redirect_valid", 64'(redirect_valid), 64'(m_pend));
    check("redirect_pc", 64'(redirect_pc), 64'(m_pc));
    check("mispredict_cnt", 64'(mispredict_cnt), 64'(m_cnt));
    check("sat_flush", 64'(s_flush), 64'(m_active));
    check("sat_valid", 64'(s_rv), 64'(m_pend));
    check("sat_cnt", 64'(s_cnt), 64'(m_sat));
  end

  task automatic drive(input logic v, input logic br, input logic jp, input logic tk,
                       input logic pt, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [31:0] ptgt, input logic st);
    ex_valid = v; ex_is_branch = br; ex_is_jump = jp; ex_taken = tk;
    ex_pred_taken = pt; ex_pc = pc; ex_target = tgt; ex_pred_target = ptgt; stall = st;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  typedef struct {
    logic br, jp, tk, pt, st;
    logic [31:0] pc, tgt, ptgt;
    logic mp;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[8];
  int   hs0;

  initial begin
    tbl[0] = '{0, 1, 0, 0, 0, 32'h1000, 32'h2000, 32'h2000, 1, 32'h2000};
    tbl[1] = '{0, 1, 0, 1, 0, 32'h1000, 32'h2000, 32'h2000, 0, 32'h0};
    tbl[2] = '{0, 1, 0, 1, 0, 32'h1100, 32'h3000, 32'h3004, 1, 32'h3000};
    tbl[3] = '{1, 0, 0, 0, 0, 32'h1200, 32'h4000, 32'h4000, 0, 32'h0};
    tbl[4] = '{1, 0, 1, 1, 0, 32'h1300, 32'h5000, 32'h5000, 0, 32'h0};
    tbl[5] = '{1, 0, 1, 1, 0, 32'h1400, 32'h6000, 32'h6008, 1, 32'h6000};
    tbl[6] = '{1, 0, 0, 0, 1, 32'h1500, 32'h7000, 32'h7000, 0, 32'h0};
    tbl[7] = '{1, 0, 0, 1, 0, 32'h0200, 32'h8000, 32'h8000, 1, 32'h0204};

    rst = 1'b1; redirect_ready = 1'b1;
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_taken = 0; ex_pred_taken = 0;
    ex_pc = '0; ex_target = '0; ex_pred_target = '0; stall = 0;
    repeat (3) @(negedge clk);
    check("rst_flush", 64'(flush_signal), 64'd0);
    check("rst_valid", 64'(redirect_valid), 64'd0);
    check("rst_pc", 64'(redirect_pc), 64'd0);
    check("rst_cnt", 64'(mispredict_cnt), 64'd0);
    rst = 1'b0;
    idle(3);
    check("post_rst_flush", 64'(flush_signal), 64'd0);

    // Branch predicted not-taken, resolved taken
    flush_cycles = 0;
    drive(1, 1, 0, 1, 0, 32'h40, 32'h100, 32'h0, 0);
    check("br_nt_flush", 64'(flush_signal), 64'd1);
    check("br_nt_valid", 64'(redirect_valid), 64'd1);
    check("br_nt_pc", 64'(redirect_pc), 64'h100);
    check("br_nt_cnt", 64'(mispredict_cnt), 64'd1);
    idle(1);
    check("br_nt_valid_drop", 64'(redirect_valid), 64'd0);
    idle(4);
    check("br_nt_len", 64'(flush_cycles), 64'd2);

    // Predicted taken, resolved not-taken at the top of memory: PC wraps
    drive(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h500, 32'h500, 0);
    check("wrap_pc", 64'(redirect_pc), 64'h0);
    check("wrap_valid", 64'(redirect_valid), 64'd1);
    idle(1);
    check("wrap_valid_drop", 64'(redirect_valid), 64'd0);
    idle(4);

    // Redirect held off for 5 cycles: HOLD keeps flush up until the handshake
    redirect_ready = 1'b0;
    flush_cycles = 0;
    hs0 = hs_cnt;
    drive(1, 0, 1, 1, 0, 32'h80, 32'h900, 32'h0, 0);
    idle(5);
    check("hold_flush", 64'(flush_signal), 64'd1);
    check("hold_valid", 64'(redirect_valid), 64'd1);
    redirect_ready = 1'b1;
    idle(1);
    check("hold_clear", 64'(flush_signal), 64'd0);
    idle(4);
    check("hold_len", 64'(flush_cycles), 64'd6);
    check("hold_handshakes", 64'(hs_cnt - hs0), 64'd1);
    check("hold_cnt", 64'(mispredict_cnt), 64'd3);

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Stall extends the flush; a misprediction during FLUSH is ignored
    flush_cycles = 0;
    drive(1, 1, 0, 1, 0, 32'h10, 32'h300, 32'h0, 0);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    drive(1, 1, 0, 1, 0, 32'h14, 32'h700, 32'h0, 0);
    idle(5);
    check("stall_len", 64'(flush_cycles), 64'd5);
    check("stall_cnt", 64'(mispredict_cnt), 64'd1);

    // Asynchronous reset in the middle of FLUSH
    drive(1, 1, 0, 1, 0, 32'h20, 32'h400, 32'h0, 0);
    check("midrst_pre", 64'(flush_signal), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_flush", 64'(flush_signal), 64'd0);
    check("midrst_valid", 64'(redirect_valid), 64'd0);
    check("midrst_cnt", 64'(mispredict_cnt), 64'd0);
    check("midrst_pc", 64'(redirect_pc), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Mixed jump/branch outcomes; four mispredictions saturate the 2-bit counter
    foreach (tbl[i]) begin
      drive(1, tbl[i].br, tbl[i].jp, tbl[i].tk, tbl[i].pt, tbl[i].pc, tbl[i].tgt,
            tbl[i].ptgt, tbl[i].st);
      check($sformatf("tbl%0d_flush", i), 64'(flush_signal), 64'(tbl[i].mp));
      if (tbl[i].mp) check($sformatf("tbl%0d_pc", i), 64'(redirect_pc), 64'(tbl[i].exp_pc));
      idle(4);
    end
    check("sat_cnt3", 64'(s_cnt), 64'd3);
    check("wide_cnt4", 64'(mispredict_cnt), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
